// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and 2-entry decode queue behind the instruction cache.
// Build option FETCH_RVC_EN enables compressed (16-bit) instruction support;
// without it every instruction is 32-bit and the PC always steps by 4.
module inst_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        fence_i,
   output logic [63:0] ic_pc,
   output logic        ic_invalid,
   input  logic        ic_inst_valid,
   input  logic [31:0] ic_inst,
   input  logic        ic_inst_comp,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [63:0] dec_pc,
   output logic [31:0] dec_inst,
   output logic        dec_comp
);
   localparam logic [1:0] DEPTH = 2'(QDEPTH);
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        comp;
   } entry_t;
   entry_t      q_q [2];
   entry_t      q_d [2];
   logic [63:0] pc_q, pc_d, step, redir_pc;
   logic [31:0] inst_in;
   logic [1:0]  cnt_q, cnt_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic        comp_in, push, pop, unused_ok;
`ifdef FETCH_RVC_EN
   assign comp_in   = ic_inst_comp;
   assign redir_pc  = {redirect_pc[63:1], 1'b0};
   assign unused_ok = redirect_pc[0];
`else
   assign comp_in   = 1'b0;
   assign redir_pc  = {redirect_pc[63:2], 2'b00};
   assign unused_ok = ^{redirect_pc[1:0], ic_inst_comp};
`endif
   assign inst_in    = comp_in ? {16'b0, ic_inst[15:0]} : ic_inst;
   assign step       = comp_in ? 64'd2 : 64'd4;
   assign dec_valid  = cnt_q != 2'd0;
   assign pop        = dec_valid & dec_ready;
   // fence_i also blocks push so a stray fence without redirect leaves pc untouched
   assign push       = ic_inst_valid & ~redirect & ~fence_i & ((cnt_q != DEPTH) | pop);
   assign ic_pc      = pc_q;
   assign ic_invalid = fence_i;
   assign {dec_pc, dec_inst, dec_comp} = q_q[rd_q];
   // next-state: enqueue/dequeue, PC step, redirect overrides everything
   always_comb begin
      q_d   = q_q;
      pc_d  = pc_q;
      rd_d  = pop ? ~rd_q : rd_q;
      wr_d  = push ? ~wr_q : wr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         q_d[wr_q] = '{pc: pc_q, inst: inst_in, comp: comp_in};
         pc_d      = pc_q + step;
      end
      if (redirect) begin
         pc_d  = redir_pc;
         cnt_d = 2'd0;
         rd_d  = 1'b0;
         wr_d  = 1'b0;
      end
   end
   // state registers, asynchronously cleared so fetch restarts at RESET_PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         cnt_q <= 2'd0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         q_q   <= '{default: '0};
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         q_q   <= q_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized scoreboard bench for inst_fetch against a queue-level model.
module tb_inst_fetch;
   localparam logic [63:0] RPC = 64'h1000;
   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        comp;
   } ent_t;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect, fence_i, ic_invalid, ic_inst_valid, ic_inst_comp;
   logic        dec_valid, dec_ready, dec_comp;
   logic [63:0] redirect_pc, ic_pc, dec_pc;
   logic [31:0] ic_inst, dec_inst;
   ent_t        sb [$];
   ent_t        h;
   logic [63:0] m_pc, cur_pc;
   logic        pend, mon_en;
   int          n_chk = 0, n_pass = 0;

   inst_fetch #(.RESET_PC(RPC), .QDEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .fence_i(fence_i), .ic_pc(ic_pc), .ic_invalid(ic_invalid),
      .ic_inst_valid(ic_inst_valid), .ic_inst(ic_inst), .ic_inst_comp(ic_inst_comp),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
      .dec_inst(dec_inst), .dec_comp(dec_comp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // One cycle of stimulus; the model decides what fetch should accept from the rules.
   task automatic cyc(input logic v, input logic [31:0] in, input logic c, input logic rdy,
                      input logic rd, input logic [63:0] rp, input logic fi);
      int   n;
      logic pop_m, push_m;
      ent_t e;
      ic_inst_valid = v; ic_inst = in; ic_inst_comp = c; dec_ready = rdy;
      redirect = rd; redirect_pc = rp; fence_i = fi;
      n      = sb.size();
      pop_m  = n > 0 && rdy && !rd;
      push_m = v && !rd && !fi && (n < 2 || pop_m);
      cur_pc = m_pc;
      pend   = push_m;
      if (rd) begin
`ifdef FETCH_RVC_EN
         m_pc = rp & ~64'd1;
`else
         m_pc = rp & ~64'd3;
`endif
      end else if (push_m) begin
         e.pc = m_pc;
`ifdef FETCH_RVC_EN
         e.comp = c;
         e.inst = c ? (in & 32'h0000_ffff) : in;
         m_pc   = m_pc + (c ? 64'd2 : 64'd4);
`else
         e.comp = 1'b0;
         e.inst = in;
         m_pc   = m_pc + 64'd4;
`endif
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input int k, input logic rdy);
      for (int i = 0; i < k; i++) cyc(1'b1, 32'h0000_0013, 1'b0, rdy, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst_n = 1'b0;
      ic_inst_valid = 1'b0; dec_ready = 1'b0; redirect = 1'b0; fence_i = 1'b1;
      #2;
      chk("rst_dec_valid", 64'(dec_valid), 64'd0);
      chk("rst_dec_pc", dec_pc, 64'd0);
      chk("rst_dec_inst", 64'(dec_inst), 64'd0);
      chk("rst_dec_comp", 64'(dec_comp), 64'd0);
      chk("rst_ic_pc", ic_pc, RPC);
      chk("rst_ic_invalid", 64'(ic_invalid), 64'd1);
      fence_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      m_pc = RPC; cur_pc = RPC; pend = 1'b0;
      mon_en = 1'b1;
   endtask

   // Monitor: compares the DUT head against the scoreboard and retires accepted entries.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("ic_pc", ic_pc, cur_pc);
         chk("ic_invalid", 64'(ic_invalid), 64'(fence_i));
         chk("dec_valid", 64'(dec_valid), 64'(sb.size() > int'(pend)));
         if (dec_valid && sb.size() > 0) begin
            h = sb[0];
            chk("dec_pc", dec_pc, h.pc);
            chk("dec_inst", 64'(dec_inst), 64'(h.inst));
            chk("dec_comp", 64'(dec_comp), 64'(h.comp));
            if (dec_ready && !redirect) void'(sb.pop_front());
         end
         if (redirect) sb.delete();
      end
   end

   initial begin
      logic [31:0] r;
      logic        rd;
      rst_n = 1'b0; mon_en = 1'b0; pend = 1'b0;
      ic_inst = '0; ic_inst_comp = 1'b0; redirect_pc = '0;
      @(posedge clk);
      #1;
      do_reset();
      hit(3, 1'b1);
      do_reset();
      hit(5, 1'b0);
      chk("stall_ic_pc", ic_pc, 64'h1008);
      hit(4, 1'b1);
      hit(3, 1'b0);
      cyc(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 64'h2001, 1'b0);
      chk("redir_ic_pc", ic_pc, 64'h2000);
      chk("redir_dec_valid", 64'(dec_valid), 64'd0);
      hit(3, 1'b1);
      cyc(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 64'h3000, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
      hit(3, 1'b1);
      cyc(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 64'h1000, 1'b0);
      cyc(1'b1, 32'hdead_4501, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
      cyc(1'b1, 32'h0050_0093, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
      cyc(1'b1, 32'h0000_8082, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
      hit(3, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 64'hffff_ffff_ffff_fff8, 1'b0);
      hit(4, 1'b1);
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         r  = $urandom_range(0, 99);
         rd = r < 4;
         cyc($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, rd,
             (r < 2) ? {$urandom, $urandom} : m_pc + 64'(2 * $urandom_range(0, 8)),
             rd && r < 1);
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
